// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared definitions for the OPB register bank: CTRL layout, counter width, byte-lane mapping.
package opb_register_bank_ppc2simulink_pkg;

  // CTRL bit positions in LSB-0 numbering (OPB bit 31 is position 0).
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_AUTO_BIT   = 1;
  localparam int CCOUNT_W        = 16;

  // OPB byte enable BE[0] covers DBus[0:7], which is the most significant byte.
  function automatic logic [31:0] be_to_mask(input logic [0:3] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      m[31-8*i -: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_decode.sv
// Address range check, word index, byte mask and single-cycle ack with lockout.
module opb_reg_decode
  import opb_register_bank_ppc2simulink_pkg::*;
#(
  parameter int unsigned             C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = '0,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  input  logic [0:3]              be,
  input  logic                    rnw,
  input  logic                    select,
  output logic                    wr_en,
  output logic                    rd_en,
  output logic [C_OPB_AWIDTH-1:0] idx,
  output logic [31:0]             mask,
  output logic                    xfer_ack
);

  logic [C_OPB_AWIDTH-1:0] addr;
  logic                    in_range;
  logic                    accept;

  assign addr     = abus;
  assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // The ack cycle blocks a new accept, so a held select acks every other cycle.
  assign accept   = select && in_range && !xfer_ack;
  assign wr_en    = accept && !rnw;
  assign rd_en    = accept && rnw;
  assign idx      = (addr - C_BASEADDR) >> 2;
  assign mask     = be_to_mask(be);

  // Ack follows the accepting cycle; reset drops any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) xfer_ack <= 1'b0;
    else     xfer_ack <= accept;
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS software registers to fabric, with optional shadow/commit.
module opb_register_bank_ppc2simulink
  import opb_register_bank_ppc2simulink_pkg::*;
#(
  parameter int unsigned             C_OPB_AWIDTH = 32,
  parameter int unsigned             C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int                      C_NUM_REGS   = 8,
  parameter int                      C_SHADOW     = 1,
  parameter logic [31:0]             C_RESET_VAL  = 32'h0,
  parameter string                   C_FAMILY     = "virtex5"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_update,
  output logic                       user_commit
);

  localparam bit    SHADOW        = (C_SHADOW != 0);
  localparam string unused_family = C_FAMILY;

  logic                          wr_en, rd_en;
  logic [C_OPB_AWIDTH-1:0]       idx;
  logic [31:0]                   mask, wdata, rd_word;
  logic [C_NUM_REGS-1:0][31:0]   sh, live;
  logic                          auto;
  logic [CCOUNT_W-1:0]           ccount;
  logic                          unused_seq;

  assign unused_seq = OPB_seqAddr;
  assign wdata      = OPB_DBus;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  opb_reg_decode #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR)
  ) u_decode (
    .clk      (OPB_Clk),
    .rst      (OPB_Rst),
    .abus     (OPB_ABus),
    .be       (OPB_BE),
    .rnw      (OPB_RNW),
    .select   (OPB_select),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .idx      (idx),
    .mask     (mask),
    .xfer_ack (Sl_xferAck)
  );

  genvar g;
  for (g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = live[g];
  end

  // Read mux: registers return the shadow copy, CTRL returns counter and AUTO, holes return 0.
  always_comb begin
    rd_word = '0;
    if (idx == C_NUM_REGS) begin
      rd_word = '0;
      rd_word[31 -: CCOUNT_W]  = ccount;
      rd_word[CTRL_AUTO_BIT]   = auto;
    end
    for (int i = 0; i < C_NUM_REGS; i++)
      if (idx == i) rd_word = sh[i];
  end

  // Read data is presented only in the ack cycle.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) Sl_DBus <= '0;
    else         Sl_DBus <= rd_en ? rd_word : '0;
  end

  // Register writes, CTRL handling and the update/commit strobes.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      sh          <= {C_NUM_REGS{C_RESET_VAL}};
      live        <= {C_NUM_REGS{C_RESET_VAL}};
      auto        <= 1'b0;
      ccount      <= '0;
      user_update <= '0;
      user_commit <= 1'b0;
    end else begin
      user_update <= '0;
      user_commit <= 1'b0;
      if (wr_en) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (idx == i) begin
            sh[i] <= (sh[i] & ~mask) | (wdata & mask);
            if (!SHADOW || auto) begin
              live[i] <= (live[i] & ~mask) | (wdata & mask);
              if (|mask) user_update[i] <= 1'b1;
            end
          end
        end
        if (idx == C_NUM_REGS) begin
          // Commit uses the shadows as they stand before this write; AUTO takes effect afterwards.
          if (SHADOW && mask[CTRL_COMMIT_BIT] && wdata[CTRL_COMMIT_BIT]) begin
            live        <= sh;
            user_update <= '1;
            user_commit <= 1'b1;
            ccount      <= ccount + 1'b1;
          end
          if (mask[CTRL_AUTO_BIT]) auto <= wdata[CTRL_AUTO_BIT];
        end
      end
    end
  end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank (N=8, shadowed, reset value 0x12345678).
module tb_opb_register_bank_ppc2simulink;

  localparam int N = 8;

  logic           OPB_Clk = 1'b0;
  logic           OPB_Rst;
  logic [0:31]    OPB_ABus;
  logic [0:3]     OPB_BE;
  logic [0:31]    OPB_DBus;
  logic           OPB_RNW;
  logic           OPB_select;
  logic           OPB_seqAddr;
  logic [0:31]    Sl_DBus;
  logic           Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [32*N-1:0] user_data_out;
  logic [N-1:0]   user_update;
  logic           user_commit;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] upd_ack;
  logic         cmt_ack;
  logic [31:0]  rd;
  int           lat;
  logic [5:0]   pat;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (32'h0000_0000),
    .C_HIGHADDR  (32'h0000_00FF),
    .C_NUM_REGS  (N),
    .C_SHADOW    (1),
    .C_RESET_VAL (32'h1234_5678)
  ) dut (
    .OPB_Clk       (OPB_Clk),
    .OPB_Rst       (OPB_Rst),
    .OPB_ABus      (OPB_ABus),
    .OPB_BE        (OPB_BE),
    .OPB_DBus      (OPB_DBus),
    .OPB_RNW       (OPB_RNW),
    .OPB_select    (OPB_select),
    .OPB_seqAddr   (OPB_seqAddr),
    .Sl_DBus       (Sl_DBus),
    .Sl_xferAck    (Sl_xferAck),
    .Sl_errAck     (Sl_errAck),
    .Sl_retry      (Sl_retry),
    .Sl_toutSup    (Sl_toutSup),
    .user_data_out (user_data_out),
    .user_update   (user_update),
    .user_commit   (user_commit)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return user_data_out[32*i +: 32];
  endfunction

  // One transfer; lat = cycles from select to ack (-1 if none within 4 cycles).
  task automatic xfer(input logic [31:0] a, input logic rnw, input logic [3:0] be,
                      input logic [31:0] d, output logic [31:0] rdata, output int latency);
    @(negedge OPB_Clk);
    OPB_ABus = a; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = d; OPB_select = 1'b1;
    latency = -1; rdata = '0; upd_ack = '0; cmt_ack = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge OPB_Clk); #1;
      if (Sl_xferAck) begin
        latency = c; rdata = Sl_DBus; upd_ack = user_update; cmt_ack = user_commit;
        break;
      end
    end
    @(negedge OPB_Clk);
    OPB_select = 1'b0;
  endtask

  initial begin
    OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0;
    OPB_RNW = 1'b0; OPB_select = 1'b0; OPB_seqAddr = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk); OPB_Rst = 1'b0;
    @(posedge OPB_Clk); #1;

    // Reset state
    for (int i = 0; i < N; i++) check($sformatf("rst_word%0d", i), word(i), 32'h1234_5678);
    check("rst_ack", {31'b0, Sl_xferAck}, 32'h0);
    check("rst_update", {24'b0, user_update}, 32'h0);
    check("rst_commit", {31'b0, user_commit}, 32'h0);
    xfer(32'h20, 1'b1, 4'hF, 32'h0, rd, lat);
    check("rst_ctrl", rd, 32'h0);

    // Shadow write: live untouched, shadow reads back
    xfer(32'h0C, 1'b0, 4'hF, 32'hDEAD_BEEF, rd, lat);
    check("sh_lat", lat, 32'd1);
    check("sh_update", {24'b0, upd_ack}, 32'h0);
    check("sh_live3", word(3), 32'h1234_5678);
    xfer(32'h0C, 1'b1, 4'hF, 32'h0, rd, lat);
    check("sh_rd_lat", lat, 32'd1);
    check("sh_readback", rd, 32'hDEAD_BEEF);

    // Commit
    xfer(32'h20, 1'b0, 4'hF, 32'h0000_0001, rd, lat);
    check("cm_live3", word(3), 32'hDEAD_BEEF);
    check("cm_live0", word(0), 32'h1234_5678);
    check("cm_update", {24'b0, upd_ack}, 32'hFF);
    check("cm_commit", {31'b0, cmt_ack}, 32'h1);
    @(posedge OPB_Clk); #1;
    check("cm_update_off", {24'b0, user_update}, 32'h0);
    check("cm_commit_off", {31'b0, user_commit}, 32'h0);
    xfer(32'h20, 1'b1, 4'hF, 32'h0, rd, lat);
    check("cm_ctrl", rd, 32'h0001_0000);

    // AUTO and byte enables
    xfer(32'h20, 1'b0, 4'hF, 32'h0000_0002, rd, lat);
    check("auto_no_commit", {31'b0, cmt_ack}, 32'h0);
    xfer(32'h20, 1'b1, 4'hF, 32'h0, rd, lat);
    check("auto_ctrl", rd, 32'h0001_0002);
    xfer(32'h00, 1'b0, 4'b0010, 32'hAABB_CCDD, rd, lat);
    check("be_live0", word(0), 32'h1234_CC78);
    check("be_update", {24'b0, upd_ack}, 32'h01);
    @(posedge OPB_Clk); #1;
    check("be_update_off", {24'b0, user_update}, 32'h0);
    xfer(32'h00, 1'b0, 4'b0000, 32'hFFFF_FFFF, rd, lat);
    check("be0_lat", lat, 32'd1);
    check("be0_live0", word(0), 32'h1234_CC78);
    check("be0_update", {24'b0, upd_ack}, 32'h0);

    // Decode edges
    xfer(32'h24, 1'b1, 4'hF, 32'h0, rd, lat);
    check("hole_lat", lat, 32'd1);
    check("hole_data", rd, 32'h0);
    xfer(32'h103, 1'b1, 4'hF, 32'h0, rd, lat);
    check("oor_noack", lat, -1);
    @(negedge OPB_Clk);
    OPB_ABus = 32'h0C; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
    #1 pat[5] = Sl_xferAck;
    for (int c = 4; c >= 0; c--) begin
      @(posedge OPB_Clk); #1;
      pat[c] = Sl_xferAck;
    end
    @(negedge OPB_Clk); OPB_select = 1'b0;
    check("held_pattern", {26'b0, pat}, 32'b010101);

    // Counter wrap: preload to 0xFFFE, then two commits
    @(negedge OPB_Clk);
    force dut.ccount = 16'hFFFE;
    @(posedge OPB_Clk); #1;
    release dut.ccount;
    xfer(32'h20, 1'b0, 4'hF, 32'h0000_0003, rd, lat);
    xfer(32'h20, 1'b1, 4'hF, 32'h0, rd, lat);
    check("wrap_ffff", rd, 32'hFFFF_0002);
    xfer(32'h20, 1'b0, 4'hF, 32'h0000_0003, rd, lat);
    xfer(32'h20, 1'b1, 4'hF, 32'h0, rd, lat);
    check("wrap_zero", rd, 32'h0000_0002);

    // Reset hitting an accepted transfer
    @(negedge OPB_Clk);
    OPB_ABus = 32'h00; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'h5555_5555; OPB_select = 1'b1;
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b1;
    #1 check("rstmid_ack", {31'b0, Sl_xferAck}, 32'h0);
    @(posedge OPB_Clk); #1;
    check("rstmid_ack2", {31'b0, Sl_xferAck}, 32'h0);
    check("rstmid_live0", word(0), 32'h1234_5678);
    check("rstmid_live3", word(3), 32'h1234_5678);
    @(negedge OPB_Clk); OPB_select = 1'b0; OPB_Rst = 1'b0;
    xfer(32'h00, 1'b1, 4'hF, 32'h0, rd, lat);
    check("rstmid_sh0", rd, 32'h1234_5678);
    xfer(32'h20, 1'b1, 4'hF, 32'h0, rd, lat);
    check("rstmid_ctrl", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
